// File: rtl/serial_sub_if.sv
// rtl/serial_sub_if.sv - start/busy/done operand and result bundle for serial_sub
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  // Requester drives the operands and start; the subtractor answers with status and result.
  modport master (
    output start, a, b,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first unsigned subtractor with registered borrow
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_sub_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_d;
  logic             w_bnext;
  logic             w_last;

  // Full-subtract cell on the current LSBs, using the borrow carried from the previous bit.
  assign w_d     = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_bnext = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: start is only honoured in IDLE, DONE always lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one bit per RUN cycle, publish result on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_sr   <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sa  <= bus.a;
            r_sb  <= bus.b;
            r_br  <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sr  <= {w_d, r_sr[WIDTH-1:1]};
          r_br  <= w_bnext;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff <= {w_d, r_sr[WIDTH-1:1]};
            r_bout <= w_bnext;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
endmodule
